lane_event_collector: RTL and testbench

Clocked collector that sits directly downstream of the latch stage driving the `w` members of an array of `I` interfaces. It samples every lane's `w`, counts its rising edges in per-lane saturating counters, and serialises non-zero lane counts onto a single valid/ready output stream. A round-robin scheme keeps lanes from starving. It is the first flop-based consumer of the latched lane array and turns level-sensitive lane state into handshaked event records.

---
 rtl/lane_event_collector_if.sv | 5 +
 rtl/lane_event_collector.sv | 131 +++++++++++++
 tb/tb_lane_event_collector.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_event_collector_if.sv
// Lane interface I: one latched level per lane. Modport P3 is the collector's read-only view.
interface I;
    logic w;
    modport P3 (input w);
endinterface

// File: rtl/lane_event_collector.sv
// Samples each lane's w, counts rising edges in saturating per-lane counters and serialises
// non-zero counts round-robin onto a valid/ready stream. Option: LANE_EVENT_COLLECTOR_SYNC2_EN.
module lane_event_collector #(
    parameter int SIZE  = 8,
    parameter int CNT_W = 4,
    localparam int LW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic             i_clk,
    input  logic             i_arst,
    I.P3                     p3 [SIZE-1:0],
    input  logic             i_ready,
    output logic             o_valid,
    output logic [LW-1:0]    o_lane,
    output logic [CNT_W-1:0] o_count,
    output logic [SIZE-1:0]  o_pending
);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t           r_state;
    logic [SIZE-1:0]  w_w;
    logic [SIZE-1:0]  r_smp;
    logic [SIZE-1:0]  r_prv;
    logic [SIZE-1:0]  w_edge;
    logic [CNT_W-1:0] r_cnt [SIZE];
    logic [LW-1:0]    r_ptr;
    logic [LW-1:0]    r_lane;
    logic [CNT_W-1:0] r_count;
    logic [LW-1:0]    w_sel;
    logic [LW-1:0]    w_ptr_nxt;
    logic             w_found;
    logic             w_load;

    for (genvar g = 0; g < SIZE; g++) begin : g_lane
        assign w_w[g]       = p3[g].w;
        assign o_pending[g] = |r_cnt[g];
    end

`ifdef LANE_EVENT_COLLECTOR_SYNC2_EN
    logic [SIZE-1:0] r_meta;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_meta <= '0;
            r_smp  <= '0;
            r_prv  <= '0;
        end else begin
            r_meta <= w_w;
            r_smp  <= r_meta;
            r_prv  <= r_smp;
        end
    end
`else
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_smp <= '0;
            r_prv <= '0;
        end else begin
            r_smp <= w_w;
            r_prv <= r_smp;
        end
    end
`endif

    assign w_edge = r_smp & ~r_prv;

    // First lane with a non-zero count, scanning upward from r_ptr with wrap.
    always_comb begin : arb
        int unsigned idx;
        w_found = 1'b0;
        w_sel   = '0;
        idx     = 0;
        for (int unsigned k = 0; k < SIZE; k++) begin
            idx = (32'(r_ptr) + k) % SIZE;
            if (!w_found && r_cnt[LW'(idx)] != '0) begin
                w_found = 1'b1;
                w_sel   = LW'(idx);
            end
        end
    end

    assign w_load    = (r_state == S_IDLE) || i_ready;
    assign w_ptr_nxt = (w_sel == LW'(SIZE - 1)) ? '0 : w_sel + 1'b1;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                // A lane being loaded restarts at its coincident edge, so that edge is not lost.
                if (w_load && w_found && w_sel == LW'(i)) begin
                    r_cnt[i] <= CNT_W'(w_edge[i]);
                end else if (w_edge[i] && r_cnt[i] != '1) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state <= S_IDLE;
            r_lane  <= '0;
            r_count <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (w_load) begin
                        if (w_found) begin
                            r_state <= S_HOLD;
                            r_lane  <= w_sel;
                            r_count <= r_cnt[w_sel];
                            r_ptr   <= w_ptr_nxt;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_valid = (r_state == S_HOLD);
    assign o_lane  = r_lane;
    assign o_count = r_count;

endmodule

// File: tb/tb_lane_event_collector.sv
// Directed bench for lane_event_collector: per-cycle comparison against a behavioural model
// plus literal expectations at key points. Honours LANE_EVENT_COLLECTOR_SYNC2_EN.
`timescale 1ns/1ps
module tb_lane_event_collector;

    localparam int SIZE  = 8;
    localparam int CNT_W = 4;
    localparam int MAXC  = 15;
`ifdef LANE_EVENT_COLLECTOR_SYNC2_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rdy = 1'b0;
    logic [SIZE-1:0] w   = '0;
    logic            o_valid;
    logic [2:0]      o_lane;
    logic [3:0]      o_count;
    logic [7:0]      o_pending;

    int n_checks = 0;
    int n_fail   = 0;
    int logq[$];

    I lanes [SIZE-1:0] ();
    for (genvar g = 0; g < SIZE; g++) begin : g_drv
        assign lanes[g].w = w[g];
    end

    lane_event_collector #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .i_clk    (clk),
        .i_arst   (rst),
        .p3       (lanes),
        .i_ready  (rdy),
        .o_valid  (o_valid),
        .o_lane   (o_lane),
        .o_count  (o_count),
        .o_pending(o_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_log(input string name, input int n, input int exp [4]);
        check({name, "_len"}, logq.size(), n);
        for (int i = 0; i < n && i < logq.size(); i++) begin
            check(name, logq[i], exp[i]);
        end
    endtask

    // Behavioural model: lane history, integer counts, round-robin pointer, held record.
    int m_cnt [SIZE];
    bit m_smp [SIZE];
    bit m_prv [SIZE];
    bit m_meta[SIZE];
    bit m_rise[SIZE];
    bit m_valid = 0;
    int m_lane  = 0;
    int m_count = 0;
    int m_ptr   = 0;
    int m_pick;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++) begin
                m_cnt[i] = 0; m_smp[i] = 0; m_prv[i] = 0; m_meta[i] = 0;
            end
            m_valid = 0; m_lane = 0; m_count = 0; m_ptr = 0;
        end else begin
            for (int i = 0; i < SIZE; i++) m_rise[i] = m_smp[i] && !m_prv[i];
            m_pick = -1;
            if (!m_valid || rdy) begin
                for (int k = 0; k < SIZE; k++)
                    if (m_pick < 0 && m_cnt[(m_ptr + k) % SIZE] > 0) m_pick = (m_ptr + k) % SIZE;
                m_valid = (m_pick >= 0);
                if (m_pick >= 0) begin
                    m_lane  = m_pick;
                    m_count = m_cnt[m_pick];
                    m_ptr   = (m_pick + 1) % SIZE;
                end
            end
            for (int i = 0; i < SIZE; i++) begin
                if (i == m_pick) m_cnt[i] = m_rise[i] ? 1 : 0;
                else if (m_rise[i]) m_cnt[i] = (m_cnt[i] + 1 > MAXC) ? MAXC : m_cnt[i] + 1;
                m_prv[i] = m_smp[i];
`ifdef LANE_EVENT_COLLECTOR_SYNC2_EN
                m_smp[i]  = m_meta[i];
                m_meta[i] = w[i];
`else
                m_smp[i] = w[i];
`endif
            end
        end
    end

    function automatic logic [SIZE-1:0] pend_model();
        logic [SIZE-1:0] p;
        for (int i = 0; i < SIZE; i++) p[i] = (m_cnt[i] > 0);
        return p;
    endfunction

    always @(posedge clk) begin
        #2;
        check("cyc_valid", o_valid, m_valid);
        check("cyc_pending", o_pending, pend_model());
        if (m_valid) begin
            check("cyc_lane", o_lane, m_lane);
            check("cyc_count", o_count, m_count);
            check("cyc_count_nonzero", o_count != 0, 1);
        end
    end

    always @(posedge clk) begin
        if (!rst && o_valid && rdy) logq.push_back(int'(o_lane) * 16 + int'(o_count));
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; w = '0;
        tick(3);
        rst = 1'b0;
        check("rst_valid", o_valid, 0);
        check("rst_pending", o_pending, 0);
        check("rst_lane", o_lane, 0);
        check("rst_count", o_count, 0);

        // Single edge on lane 2
        logq.delete();
        w[2] = 1'b1;
        for (int c = 1; c < LAT; c++) begin
            tick(1);
            check("t1_latency", o_valid, 0);
            if (c == LAT - 1) check("t1_pending", o_pending, 8'h04);
        end
        tick(1);
        check("t1_valid", o_valid, 1);
        check("t1_lane", o_lane, 2);
        check("t1_count", o_count, 1);
        check("t1_pending_clr", o_pending, 0);
        tick(1);
        check("t1_drop", o_valid, 0);
        check_log("t1_log", 1, '{'h21, 0, 0, 0});

        // Saturation on lane 0 while the output is stalled
        w[2] = 1'b0; rdy = 1'b0;
        tick(2);
        logq.delete();
        for (int t = 0; t < 20; t++) begin
            w[0] = 1'b1; tick(2);
            w[0] = 1'b0; tick(2);
        end
        check("t2_valid", o_valid, 1);
        check("t2_lane", o_lane, 0);
        check("t2_hold_count", o_count, 1);
        check("t2_pending", o_pending, 8'h01);
        rdy = 1'b1;
        tick(1);
        check("t2_sat_count", o_count, 15);
        tick(1);
        check("t2_drop", o_valid, 0);
        check_log("t2_log", 2, '{'h01, 'h0F, 0, 0});

        // Three lanes together, then round-robin wrap back to lane 1
        logq.delete();
        w[1] = 1'b1; w[5] = 1'b1; w[7] = 1'b1;
        tick(LAT);
        check("t3_lane_a", o_lane, 1);
        tick(1);
        check("t3_lane_b", o_lane, 5);
        tick(1);
        check("t3_lane_c", o_lane, 7);
        tick(1);
        check("t3_drop", o_valid, 0);
        w[1] = 1'b0; tick(2);
        w[1] = 1'b1; tick(LAT + 1);
        check_log("t3_log", 4, '{'h11, 'h51, 'h71, 'h11});

        // Edge on lane 4 coincides with its load
        w = '0; rdy = 1'b0;
        tick(2);
        logq.delete();
        w[6] = 1'b1;
        tick(LAT + 1);
        check("t4_hold6", o_lane, 6);
        w[4] = 1'b1; tick(2);
        w[4] = 1'b0; tick(2);
        w[4] = 1'b1; tick(LAT - 2);
        rdy = 1'b1;
        tick(1);
        check("t4_lane", o_lane, 4);
        check("t4_count", o_count, 1);
        check("t4_pending", o_pending, 8'h10);
        tick(1);
        check("t4_again_valid", o_valid, 1);
        check("t4_again_lane", o_lane, 4);
        check("t4_again_count", o_count, 1);
        check("t4_again_pending", o_pending, 0);
        tick(1);
        check("t4_drop", o_valid, 0);
        check_log("t4_log", 3, '{'h61, 'h41, 'h41, 0});

        // Asynchronous reset while a record is presented
        w = '0; rdy = 1'b0;
        tick(2);
        logq.delete();
        w[3] = 1'b1; w[5] = 1'b1;
        tick(LAT + 1);
        check("t5_valid", o_valid, 1);
        check("t5_lane", o_lane, 5);
        check("t5_pending", o_pending, 8'h08);
        #2 rst = 1'b1;
        #1;
        check("t5_async_valid", o_valid, 0);
        check("t5_async_pending", o_pending, 0);
        w = '0;
        tick(1);
        rst = 1'b0; rdy = 1'b1;
        tick(6);
        check("t5_no_stale", o_valid, 0);
        check_log("t5_log", 0, '{0, 0, 0, 0});

        // Lane 3 high through reset release
        rst = 1'b1;
        w[3] = 1'b1;
        tick(2);
        logq.delete();
        rst = 1'b0;
        for (int c = 1; c < LAT; c++) begin
            tick(1);
            check("t6_latency", o_valid, 0);
        end
        tick(1);
        check("t6_valid", o_valid, 1);
        check("t6_lane", o_lane, 3);
        check("t6_count", o_count, 1);
        tick(3);
        check("t6_drop", o_valid, 0);
        check_log("t6_log", 1, '{'h31, 0, 0, 0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
